// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALUcontrol codes, R-type funct
// codes, aluop codes, FSM state type and the decode result bundle.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_HOLD = 4'b1111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       is_slt;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channels between the decode/issue stage (master) and the
// ALU issue controller (slave).
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [31:0]      req_opa;
    logic [31:0]      req_opb;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_aluop, req_funct, req_opa, req_opb, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_aluop, req_funct, req_opa, req_opb, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct decode to ALUcontrol code, slt marker and illegal flag.
// Optional feature macro: ALU_ISSUE_SLT_EN (makes funct 101010 legal as slt).
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output decode_t    dec
);

    // aluop/funct lookup; anything unlisted is illegal and leaves the ALU on hold
    always_comb begin
        dec.ctrl    = ALU_HOLD;
        dec.is_slt  = 1'b0;
        dec.illegal = 1'b1;
        case (aluop)
            ALUOP_ADD: begin
                dec.ctrl    = ALU_ADD;
                dec.illegal = 1'b0;
            end
            ALUOP_SUB: begin
                dec.ctrl    = ALU_SUB;
                dec.illegal = 1'b0;
            end
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: begin dec.ctrl = ALU_ADD; dec.illegal = 1'b0; end
                    FUNCT_SUB: begin dec.ctrl = ALU_SUB; dec.illegal = 1'b0; end
                    FUNCT_AND: begin dec.ctrl = ALU_AND; dec.illegal = 1'b0; end
                    FUNCT_OR:  begin dec.ctrl = ALU_OR;  dec.illegal = 1'b0; end
                    FUNCT_NOR: begin dec.ctrl = ALU_NOR; dec.illegal = 1'b0; end
                    FUNCT_SLL: begin dec.ctrl = ALU_SLL; dec.illegal = 1'b0; end
`ifdef ALU_ISSUE_SLT_EN
                    // slt rides on the ALU subtractor; the sign fix-up happens at capture
                    FUNCT_SLT: begin
                        dec.ctrl    = ALU_SUB;
                        dec.is_slt  = 1'b1;
                        dec.illegal = 1'b0;
                    end
`else
                    FUNCT_SLT: begin
                        dec.ctrl    = ALU_HOLD;
                        dec.illegal = 1'b1;
                    end
`endif
                    default: begin
                        dec.ctrl    = ALU_HOLD;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec.ctrl    = ALU_HOLD;
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request, drives the ALU, waits ALU_LAT cycles,
// returns the sampled result. Optional feature macro: ALU_ISSUE_SLT_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        alu_ctrl,
    output logic [31:0]       alu_op1,
    output logic [31:0]       alu_op2,
    input  logic [31:0]       alu_out,
    input  logic              alu_zero
);

    state_t           state_r;
    state_t           state_nxt_s;
    decode_t          dec_s;
    logic             accept_s;
    logic             capture_s;
    logic             rsp_hs_s;
    logic [3:0]       cnt_r;
    logic             is_slt_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic [3:0]       alu_ctrl_r;
    logic [31:0]      alu_op1_r;
    logic [31:0]      alu_op2_r;
    logic             slt_bit_s;
    logic [31:0]      cap_result_s;
    logic             cap_zero_s;

    alu_ctrl_decode u_decode (
        .aluop (bus.req_aluop),
        .funct (bus.req_funct),
        .dec   (dec_s)
    );

    assign accept_s  = (state_r == S_IDLE) && bus.req_valid && req_ready_r;
    assign capture_s = (state_r == S_WAIT) && (cnt_r == 4'd0);
    assign rsp_hs_s  = (state_r == S_RESP) && bus.rsp_ready;

    // Value to latch at capture: raw ALU output, or slt built from the subtract sign
    always_comb begin
        slt_bit_s = (alu_op1_r[31] ^ alu_op2_r[31]) ? alu_op1_r[31] : alu_out[31];
        if (is_slt_r) begin
            cap_result_s = {31'd0, slt_bit_s};
            cap_zero_s   = ~slt_bit_s;
        end else begin
            cap_result_s = alu_out;
            cap_zero_s   = alu_zero;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state; illegal requests skip the ALU and go straight to RESP
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = dec_s.illegal ? S_RESP : S_ISSUE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (capture_s) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RESP;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath: capture request, count ALU settle time, hold response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= 4'd0;
            is_slt_r     <= 1'b0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'd0;
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            rsp_tag_r    <= '0;
            alu_ctrl_r   <= ALU_HOLD;
            alu_op1_r    <= 32'd0;
            alu_op2_r    <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        rsp_tag_r   <= bus.req_tag;
                        if (dec_s.illegal) begin
                            rsp_valid_r  <= 1'b1;
                            rsp_err_r    <= 1'b1;
                            rsp_result_r <= 32'd0;
                            rsp_zero_r   <= 1'b0;
                        end else begin
                            rsp_err_r  <= 1'b0;
                            alu_ctrl_r <= dec_s.ctrl;
                            alu_op1_r  <= bus.req_opa;
                            alu_op2_r  <= bus.req_opb;
                            is_slt_r   <= dec_s.is_slt;
                            cnt_r      <= 4'(ALU_LAT);
                        end
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (capture_s) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= cap_result_s;
                        rsp_zero_r   <= cap_zero_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= 1'b0;
                        alu_ctrl_r  <= ALU_HOLD;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    alu_ctrl_r  <= ALU_HOLD;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.rsp_tag    = rsp_tag_r;
    assign alu_ctrl       = alu_ctrl_r;
    assign alu_op1        = alu_op1_r;
    assign alu_op2        = alu_op2_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model.
// Honours ALU_ISSUE_SLT_EN for the slt scenario.
module tb_alu_issue_ctrl;

    localparam int ALU_LAT = 2;
    localparam int TAG_W   = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_out;
    logic        alu_zero;

    int n_checks;
    int n_fail;

    alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_ctrl (alu_ctrl),
        .alu_op1  (alu_op1),
        .alu_op2  (alu_op2),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_out = alu_op1 + alu_op2;
            4'b0110: alu_out = alu_op1 - alu_op2;
            4'b0000: alu_out = alu_op1 & alu_op2;
            4'b0001: alu_out = alu_op1 | alu_op2;
            4'b0011: alu_out = ~(alu_op1 | alu_op2);
            4'b1001: alu_out = alu_op1 << alu_op2[4:0];
            default: alu_out = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    // Drive one request; report ctrl seen right after the accept edge and edges to rsp_valid
    task automatic do_req(input logic [1:0] aluop, input logic [5:0] funct,
                          input logic [31:0] opa, input logic [31:0] opb,
                          input logic [3:0] tag, output logic [3:0] ctrl_t0, output int lat);
        bus.req_aluop = aluop;
        bus.req_funct = funct;
        bus.req_opa   = opa;
        bus.req_opb   = opb;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        ctrl_t0 = alu_ctrl;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_checks++; if (alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL reset_alu_ctrl got %b want 1111", alu_ctrl); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin n_fail++; $display("FAIL reset_ops got %h/%h want 0/0", alu_op1, alu_op2); end
        n_checks++; if (bus.rsp_result !== 32'd0 || bus.rsp_err !== 1'b0 || bus.rsp_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_rsp got %h/%b/%h want 0/0/0", bus.rsp_result, bus.rsp_err, bus.rsp_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_spurious got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_add_funct();
        logic [3:0] c;
        int l;
        do_req(2'b10, 6'b100000, 32'd5, 32'd7, 4'd3, c, l);
        n_checks++; if (c !== 4'b0010) begin n_fail++; $display("FAIL add_ctrl got %b want 0010", c); end
        n_checks++; if (l !== 3) begin n_fail++; $display("FAIL add_latency got %0d want 3", l); end
        n_checks++; if (bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL add_rsp got %h/%b/%b want 0000000c/0/0", bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
        n_checks++; if (bus.rsp_tag !== 4'd3) begin n_fail++; $display("FAIL add_tag got %h want 3", bus.rsp_tag); end
        n_checks++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin n_fail++; $display("FAIL add_ops got %h/%h want 5/7", alu_op1, alu_op2); end
        take_rsp();
        n_checks++; if (bus.rsp_valid !== 1'b0 || alu_ctrl !== 4'b1111 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_handshake got v=%b ctrl=%b rdy=%b want 0/1111/1", bus.rsp_valid, alu_ctrl, bus.req_ready); end
    endtask

    task automatic test_sub_stall();
        logic [3:0] c;
        int l;
        do_req(2'b01, 6'b000000, 32'h1234, 32'h1234, 4'd5, c, l);
        n_checks++; if (c !== 4'b0110) begin n_fail++; $display("FAIL sub_ctrl got %b want 0110", c); end
        n_checks++; if (l !== 3) begin n_fail++; $display("FAIL sub_latency got %0d want 3", l); end
        // Present a competing request while busy; it must be ignored
        bus.req_valid = 1'b1;
        bus.req_aluop = 2'b00;
        bus.req_opa   = 32'h1;
        bus.req_opb   = 32'h1;
        bus.req_tag   = 4'hA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.rsp_tag !== 4'd5) begin
                n_fail++; $display("FAIL sub_stall_rsp cyc %0d got v=%b r=%h z=%b t=%h want 1/0/1/5", i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag); end
            n_checks++; if (bus.req_ready !== 1'b0 || alu_ctrl !== 4'b0110) begin
                n_fail++; $display("FAIL sub_stall_hold cyc %0d got rdy=%b ctrl=%b want 0/0110", i, bus.req_ready, alu_ctrl); end
        end
        bus.req_valid = 1'b0;
        take_rsp();
        n_checks++; if (bus.rsp_valid !== 1'b0 || alu_ctrl !== 4'b1111 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL sub_handshake got v=%b ctrl=%b rdy=%b want 0/1111/1", bus.rsp_valid, alu_ctrl, bus.req_ready); end
    endtask

    task automatic test_illegal();
        logic [3:0] c;
        int l;
        do_req(2'b10, 6'b111111, 32'd9, 32'd9, 4'd9, c, l);
        n_checks++; if (l !== 0) begin n_fail++; $display("FAIL illegal_funct_latency got %0d want 0", l); end
        n_checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_tag !== 4'd9) begin
            n_fail++; $display("FAIL illegal_funct_rsp got e=%b r=%h z=%b t=%h want 1/0/0/9", bus.rsp_err, bus.rsp_result, bus.rsp_zero, bus.rsp_tag); end
        n_checks++; if (c !== 4'b1111 || alu_ctrl !== 4'b1111) begin n_fail++; $display("FAIL illegal_funct_ctrl got %b/%b want 1111", c, alu_ctrl); end
        take_rsp();
        do_req(2'b11, 6'b100000, 32'd1, 32'd1, 4'd2, c, l);
        n_checks++; if (l !== 0 || bus.rsp_err !== 1'b1 || c !== 4'b1111) begin
            n_fail++; $display("FAIL illegal_aluop got lat=%0d e=%b ctrl=%b want 0/1/1111", l, bus.rsp_err, c); end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        logic [3:0] c;
        int l;
        bus.req_aluop = 2'b10;
        bus.req_funct = 6'b100100;
        bus.req_opa   = 32'hFF00_FF00;
        bus.req_opb   = 32'h0F0F_0F0F;
        bus.req_tag   = 4'd7;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_checks++; if (alu_ctrl !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ctrl got %b want 0000", alu_ctrl); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        n_checks++; if (alu_ctrl !== 4'b1111 || alu_op1 !== 32'd0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_tag !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got ctrl=%b op1=%h rdy=%b v=%b t=%h want 1111/0/1/0/0", alu_ctrl, alu_op1, bus.req_ready, bus.rsp_valid, bus.rsp_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp got %b want 0", bus.rsp_valid); end
        do_req(2'b00, 6'b111111, 32'h0000_00F0, 32'h0000_000F, 4'd1, c, l);
        n_checks++; if (c !== 4'b0010 || l !== 3 || bus.rsp_result !== 32'h0000_00FF || bus.rsp_tag !== 4'd1) begin
            n_fail++; $display("FAIL rstmid_next got ctrl=%b lat=%0d r=%h t=%h want 0010/3/000000ff/1", c, l, bus.rsp_result, bus.rsp_tag); end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  v_op  [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [5:0]  v_fn  [5] = '{6'b100101, 6'b100111, 6'b000000, 6'b100010, 6'b000000};
        logic [31:0] v_a   [5] = '{32'hF0F0_0000, 32'hFFFF_0000, 32'h0000_0001, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] v_b   [5] = '{32'h0000_0F0F, 32'h0000_00FF, 32'd4, 32'd5, 32'd1};
        logic [3:0]  v_c   [5] = '{4'b0001, 4'b0011, 4'b1001, 4'b0110, 4'b0010};
        logic [31:0] v_r   [5] = '{32'hF0F0_0F0F, 32'h0000_FF00, 32'd16, 32'hFFFF_FFFE, 32'd0};
        logic        v_z   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] c;
        int l;
        for (int i = 0; i < 5; i++) begin
            do_req(v_op[i], v_fn[i], v_a[i], v_b[i], 4'(i + 8), c, l);
            n_checks++; if (c !== v_c[i] || l !== 3) begin
                n_fail++; $display("FAIL b2b_%0d_ctrl got ctrl=%b lat=%0d want %b/3", i, c, l, v_c[i]); end
            n_checks++; if (bus.rsp_result !== v_r[i] || bus.rsp_zero !== v_z[i] || bus.rsp_tag !== 4'(i + 8)) begin
                n_fail++; $display("FAIL b2b_%0d_rsp got r=%h z=%b t=%h want %h/%b/%h", i, bus.rsp_result, bus.rsp_zero, bus.rsp_tag, v_r[i], v_z[i], 4'(i + 8)); end
            take_rsp();
        end
    endtask

    task automatic test_slt();
        logic [3:0] c;
        int l;
`ifdef ALU_ISSUE_SLT_EN
        do_req(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'd4, c, l);
        n_checks++; if (c !== 4'b0110 || l !== 3 || bus.rsp_result !== 32'd1 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL slt_neg_pos got ctrl=%b lat=%0d r=%h z=%b e=%b want 0110/3/1/0/0", c, l, bus.rsp_result, bus.rsp_zero, bus.rsp_err); end
        take_rsp();
        do_req(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 4'd5, c, l);
        n_checks++; if (l !== 3 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
            n_fail++; $display("FAIL slt_pos_neg got lat=%0d r=%h z=%b want 3/0/1", l, bus.rsp_result, bus.rsp_zero); end
        take_rsp();
        do_req(2'b10, 6'b101010, 32'd3, 32'd5, 4'd6, c, l);
        n_checks++; if (bus.rsp_result !== 32'd1 || bus.rsp_zero !== 1'b0) begin
            n_fail++; $display("FAIL slt_same_sign got r=%h z=%b want 1/0", bus.rsp_result, bus.rsp_zero); end
        take_rsp();
`else
        do_req(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'd4, c, l);
        n_checks++; if (l !== 0 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'd0 || c !== 4'b1111) begin
            n_fail++; $display("FAIL slt_disabled got lat=%0d e=%b r=%h ctrl=%b want 0/1/0/1111", l, bus.rsp_err, bus.rsp_result, c); end
        take_rsp();
`endif
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.req_valid = 1'b0;
        bus.req_aluop = 2'b00;
        bus.req_funct = 6'b000000;
        bus.req_opa   = 32'd0;
        bus.req_opb   = 32'd0;
        bus.req_tag   = 4'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add_funct();
        test_sub_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_slt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
